game_sequencer: RTL and testbench

Top-level game-flow controller for the brick-breaker datapath. It owns the game state machine, startup/serve delay, life and score bookkeeping, and the movement-step enable that paces the ball engine. It sits between the board-level buttons and the ball/paddle/brick logic. The ball engine becomes a pure datapath: it steps on `move_tick`, reports `miss_evt`/`brick_hit`, and re-centres on `ball_reset`.

---
 rtl/game_pkg.sv | 23 ++
 rtl/game_sequencer_tick_divider.sv | 30 +++
 rtl/game_sequencer.sv | 116 +++++++++++
 tb/tb_game_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared game states, board constants and colours for the brick-breaker blocks
package game_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        MISS      = 3'd3,
        WIN       = 3'd4,
        GAME_OVER = 3'd5
    } state_t;

    localparam int NUM_BLOCKS_X = 14;
    localparam int NUM_BLOCKS_Y = 4;
    localparam int NUM_BLOCKS   = NUM_BLOCKS_X * NUM_BLOCKS_Y;
    localparam int MAX_LIVES    = 3;

    localparam logic [11:0] COLOR_BG     = 12'h000;
    localparam logic [11:0] COLOR_BALL   = 12'hFFF;
    localparam logic [11:0] COLOR_PADDLE = 12'h0AF;
    localparam logic [11:0] COLOR_BRICK  = 12'hF80;

endpackage

// File: rtl/game_sequencer_tick_divider.sv
// tick_divider: one-cycle tick every DIV enabled cycles; counter freezes while disabled
module tick_divider #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // count enabled cycles, pulse tick on wrap, restart from zero on clr
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (en) begin
            cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
            tick <= cnt == LAST;
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: game-flow FSM with serve/end delays, lives, score and ball step pacing
module game_sequencer
    import game_pkg::*;
#(
    parameter int TICK_DIV    = 750000,
    parameter int SERVE_DELAY = 50000000,
    parameter int END_HOLD    = 100000000,
    parameter int MAX_LIVES   = game_pkg::MAX_LIVES,
    parameter int NUM_BLOCKS  = game_pkg::NUM_BLOCKS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_btn,
    input  logic        miss_evt,
    input  logic        brick_hit,
    output logic        move_tick,
    output logic        ball_reset,
    output logic        blocks_reset,
    output logic [3:0]  lives,
    output logic [15:0] score,
    output logic [2:0]  game_state,
    output logic        play_active
);

    localparam int DW = $clog2((SERVE_DELAY > END_HOLD ? SERVE_DELAY : END_HOLD) + 1);

    state_t        state;
    logic [DW-1:0] dcnt;
    logic          start_q;
    logic [15:0]   score_inc;
    logic          start_rise, delay_done, hold_done, win_now, go_play, stay_play;

    assign start_rise = start_btn & ~start_q;
    assign score_inc  = (score == 16'hFFFF) ? score : score + 16'd1;
    assign win_now    = brick_hit && score_inc == 16'(NUM_BLOCKS);
    assign delay_done = dcnt == DW'(SERVE_DELAY - 1);
    assign hold_done  = dcnt == DW'(END_HOLD - 1);
    assign go_play    = (state == SERVE || state == MISS) && (start_rise || delay_done);
    // the step counter only advances while PLAY persists, so no tick leaks into the next state
    assign stay_play  = state == PLAY && !win_now && !miss_evt;
    assign game_state = state;

    tick_divider #(.DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (stay_play),
        .clr  (go_play),
        .tick (move_tick)
    );

    // game state machine with inline delay counter and lives/score bookkeeping
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            lives        <= 4'(MAX_LIVES);
            score        <= '0;
            dcnt         <= '0;
            start_q      <= start_btn;
            ball_reset   <= 1'b0;
            blocks_reset <= 1'b0;
            play_active  <= 1'b0;
        end else begin
            start_q      <= start_btn;
            ball_reset   <= 1'b0;
            blocks_reset <= 1'b0;
            case (state)
                IDLE, WIN, GAME_OVER: begin
                    if (start_rise) begin
                        state        <= SERVE;
                        lives        <= 4'(MAX_LIVES);
                        score        <= '0;
                        dcnt         <= '0;
                        ball_reset   <= 1'b1;
                        blocks_reset <= 1'b1;
                    end else if (state != IDLE && hold_done) begin
                        state <= IDLE;
                        dcnt  <= '0;
                    end else if (state != IDLE) begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                SERVE, MISS: begin
                    if (go_play) begin
                        state       <= PLAY;
                        dcnt        <= '0;
                        play_active <= 1'b1;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                PLAY: begin
                    if (brick_hit) score <= score_inc;
                    if (win_now) begin
                        state       <= WIN;
                        play_active <= 1'b0;
                    end else if (miss_evt) begin
                        lives       <= lives - 4'd1;
                        play_active <= 1'b0;
                        if (lives == 4'd1) begin
                            state <= GAME_OVER;
                        end else begin
                            state      <= MISS;
                            ball_reset <= 1'b1;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    dcnt        <= '0;
                    play_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: randomized + directed stimulus against a cycle-level game-rules model
module tb_game_sequencer;

    localparam int TD   = 4;
    localparam int SD   = 8;
    localparam int EH   = 6;
    localparam int MAXL = 3;
    localparam int NB   = 5;

    localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_MISS = 3, S_WIN = 4, S_GO = 5;

    logic        clk, rst, start_btn, miss_evt, brick_hit;
    logic        move_tick, ball_reset, blocks_reset, play_active;
    logic [3:0]  lives;
    logic [15:0] score;
    logic [2:0]  game_state;

    game_sequencer #(
        .TICK_DIV(TD), .SERVE_DELAY(SD), .END_HOLD(EH), .MAX_LIVES(MAXL), .NUM_BLOCKS(NB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_btn    (start_btn),
        .miss_evt     (miss_evt),
        .brick_hit    (brick_hit),
        .move_tick    (move_tick),
        .ball_reset   (ball_reset),
        .blocks_reset (blocks_reset),
        .lives        (lives),
        .score        (score),
        .game_state   (game_state),
        .play_active  (play_active)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [2:0]  st;
        logic [3:0]  lv;
        logic [15:0] sc;
        logic        mt, br, bk, pa;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    // reference model: game rules expressed as cycles spent in a state and PLAY cycles since entry
    int m_state, m_lives, m_score, m_wait, m_phase;
    bit m_prev, e_mt, e_br, e_bk;
    bit sb;

    task automatic new_game();
        m_state = S_SERVE;
        m_lives = MAXL;
        m_score = 0;
        m_wait  = 0;
        e_br    = 1;
        e_bk    = 1;
    endtask

    task automatic model(input bit r, input bit s, input bit m, input bit h);
        bit rise;
        e_mt = 0;
        e_br = 0;
        e_bk = 0;
        if (!r) begin
            m_state = S_IDLE;
            m_lives = MAXL;
            m_score = 0;
            m_wait  = 0;
            m_phase = 0;
            m_prev  = s;
            return;
        end
        rise   = s && !m_prev;
        m_prev = s;
        case (m_state)
            S_IDLE: if (rise) new_game();
            S_SERVE, S_MISS: begin
                m_wait++;
                if (rise || m_wait == SD) begin
                    m_state = S_PLAY;
                    m_phase = 0;
                end
            end
            S_PLAY: begin
                if (h) begin
                    m_score = (m_score < 65535) ? m_score + 1 : 65535;
                    if (m_score == NB) begin
                        m_state = S_WIN;
                        m_wait  = 0;
                        return;
                    end
                end
                if (m) begin
                    m_lives--;
                    m_wait = 0;
                    if (m_lives == 0) m_state = S_GO;
                    else begin
                        m_state = S_MISS;
                        e_br    = 1;
                    end
                end else begin
                    m_phase++;
                    e_mt = (m_phase % TD) == 0;
                end
            end
            default: begin
                if (rise) new_game();
                else begin
                    m_wait++;
                    if (m_wait == EH) begin
                        m_state = S_IDLE;
                        m_wait  = 0;
                    end
                end
            end
        endcase
    endtask

    task automatic step(input bit r, input bit s, input bit m, input bit h);
        exp_t e;
        rst       = r;
        start_btn = s;
        miss_evt  = m;
        brick_hit = h;
        model(r, s, m, h);
        e.st = 3'(m_state);
        e.lv = 4'(m_lives);
        e.sc = 16'(m_score);
        e.mt = e_mt;
        e.br = e_br;
        e.bk = e_bk;
        e.pa = m_state == S_PLAY;
        expq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1, sb, 0, 0);
    endtask

    task automatic pulse(input bit h, input bit m);
        step(1, sb, m, h);
    endtask

    task automatic press();
        if (sb) begin
            sb = 0;
            step(1, 0, 0, 0);
        end
        sb = 1;
        step(1, 1, 0, 0);
    endtask

    task automatic to_play();
        for (int i = 0; i < 40 && m_state != S_PLAY; i++) step(1, sb, 0, 0);
        if (m_state != S_PLAY) begin
            errors++;
            $display("FAIL to_play: model state %0d, required %0d within 40 cycles", m_state, S_PLAY);
        end
    endtask

    task automatic chk(input string n, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", n, $time, act, req);
        end
    endtask

    // monitor: pops one expected record per clock and compares it with the DUT outputs
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            chk("game_state", 16'(game_state), 16'(e.st));
            chk("lives", 16'(lives), 16'(e.lv));
            chk("score", score, e.sc);
            chk("move_tick", 16'(move_tick), 16'(e.mt));
            chk("ball_reset", 16'(ball_reset), 16'(e.br));
            chk("blocks_reset", 16'(blocks_reset), 16'(e.bk));
            chk("play_active", 16'(play_active), 16'(e.pa));
        end
    end

    initial begin
        sb = 1;
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        idle(6);
        sb = 0;
        idle(1);
        press();
        to_play();
        idle(12);

        for (int i = 0; i < 3; i++) begin
            pulse(0, 1);
            if (i < 2) begin
                to_play();
                idle(2);
            end
        end
        idle(8);

        press();
        to_play();
        repeat (5) begin
            pulse(1, 0);
            idle(2);
        end
        idle(8);

        press();
        to_play();
        pulse(1, 0);
        pulse(1, 0);
        pulse(1, 1);
        to_play();
        pulse(1, 0);
        pulse(1, 1);
        idle(3);

        press();
        to_play();
        idle(3);
        sb = 1;
        step(0, 1, 0, 0);
        idle(4);

        press();
        to_play();
        pulse(0, 1);
        idle(2);
        step(0, 1, 0, 0);
        idle(3);

        press();
        idle(2);
        sb = 0;
        step(1, 0, 0, 0);
        sb = 1;
        step(1, 1, 0, 0);
        idle(10);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) sb = ~sb;
            step($urandom_range(0, 299) != 0, sb, $urandom_range(0, 11) == 0, $urandom_range(0, 3) == 0);
        end

        repeat (3) @(negedge clk);
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected records left, required 0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
